polirv_run_ctrl: RTL and testbench

POLIRV_RUN_CTRL -- requirements
Module: polirv_run_ctrl

---
 rtl/polirv_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_polirv_run_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polirv_run_ctrl.sv
// Run controller for a RISC-V core under test: holds the core in reset, lets it run,
// and classifies the run as pass, fail, timeout or hang from monitored memory traffic.
module polirv_run_ctrl #(
    parameter int unsigned   i_addr_bits  = 6,
    parameter int unsigned   d_addr_bits  = 6,
    parameter int unsigned   WORDSIZE     = 64,
    parameter int unsigned   CNT_BITS     = 16,
    parameter int unsigned   RST_CYCLES   = 2,
    parameter int unsigned   MAX_CYCLES   = 1024,
    parameter int unsigned   STALL_CYCLES = 8,
    parameter int unsigned   HALT_ADDR    = 63,
    parameter logic [WORDSIZE-1:0] PASS_VALUE = WORDSIZE'(1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [i_addr_bits-1:0] i_mem_addr,
    input  logic                   d_mem_we,
    input  logic [d_addr_bits-1:0] d_mem_addr,
    input  logic [WORDSIZE-1:0]    d_mem_data,
    output logic                   core_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic                   hang,
    output logic [WORDSIZE-1:0]    halt_value,
    output logic [CNT_BITS-1:0]    cycle_count,
    output logic [CNT_BITS-1:0]    write_count
);

    localparam int unsigned HW = $clog2(RST_CYCLES + 1);
    localparam int unsigned SW = $clog2(STALL_CYCLES + 1) + 1;

    typedef enum logic [2:0] {
        StIdle, StHold, StRun, StPass, StFail, StTimeout, StHang
    } state_e;

    state_e                 state_q;
    logic [HW-1:0]          hold_q;
    logic [SW-1:0]          stall_q;
    logic [i_addr_bits-1:0] prev_addr_q;
    logic                   core_rst_n_q, busy_q, done_q, pass_q, timeout_q, hang_q;
    logic [WORDSIZE-1:0]    halt_value_q;
    logic [CNT_BITS-1:0]    cycle_q, write_q;

    logic                   halt_hit, timeout_hit, hang_hit;
    logic [CNT_BITS-1:0]    cycle_inc, write_inc;
    logic [SW-1:0]          stall_inc;

    always_comb begin
        halt_hit    = d_mem_we && (d_mem_addr == d_addr_bits'(HALT_ADDR));
        cycle_inc   = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
        write_inc   = (write_q == '1) ? write_q : write_q + 1'b1;
        stall_inc   = (i_mem_addr == prev_addr_q) ? stall_q + 1'b1 : '0;
        timeout_hit = (cycle_q == CNT_BITS'(MAX_CYCLES - 1));
        hang_hit    = (STALL_CYCLES != 0) && (stall_inc == SW'(STALL_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            stall_q      <= '0;
            prev_addr_q  <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            hang_q       <= 1'b0;
            halt_value_q <= '0;
            cycle_q      <= '0;
            write_q      <= '0;
        end else begin
            // Tracked every cycle so the first RUN cycle compares against the address
            // the core was presenting while still held in reset.
            prev_addr_q <= i_mem_addr;
            case (state_q)
                StHold: begin
                    if (hold_q == HW'(RST_CYCLES - 1)) begin
                        state_q      <= StRun;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                StRun: begin
                    cycle_q <= cycle_inc;
                    if (d_mem_we) write_q <= write_inc;
                    stall_q <= (STALL_CYCLES == 0) ? '0 : stall_inc;
                    if (halt_hit || timeout_hit || hang_hit) begin
                        core_rst_n_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end
                    if (halt_hit) begin
                        halt_value_q <= d_mem_data;
                        if (d_mem_data == PASS_VALUE) begin
                            state_q <= StPass;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= StFail;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= StTimeout;
                        timeout_q <= 1'b1;
                    end else if (hang_hit) begin
                        state_q <= StHang;
                        hang_q  <= 1'b1;
                    end
                end
                default: begin
                    // Idle and all terminal states: start launches a fresh run.
                    if (start) begin
                        state_q      <= StHold;
                        hold_q       <= '0;
                        stall_q      <= '0;
                        core_rst_n_q <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        hang_q       <= 1'b0;
                        halt_value_q <= '0;
                        cycle_q      <= '0;
                        write_q      <= '0;
                    end
                end
            endcase
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign hang        = hang_q;
    assign halt_value  = halt_value_q;
    assign cycle_count = cycle_q;
    assign write_count = write_q;

endmodule

// File: tb/tb_polirv_run_ctrl.sv
// Scoreboard bench: two controllers (hang detection on / off) see identical stimulus and
// are checked against a run-level reference model.
module tb_polirv_run_ctrl;

    localparam int L = 40;

    logic        clk = 1'b0;
    logic        rst_n, start, d_mem_we;
    logic [5:0]  i_mem_addr, d_mem_addr;
    logic [63:0] d_mem_data;

    logic        a_crn, a_busy, a_done, a_pass, a_to, a_hang;
    logic [63:0] a_hv;
    logic [15:0] a_cc, a_wc;
    logic        b_crn, b_busy, b_done, b_pass, b_to, b_hang;
    logic [63:0] b_hv;
    logic [15:0] b_cc, b_wc;

    polirv_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(40), .STALL_CYCLES(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .i_mem_addr(i_mem_addr),
        .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr), .d_mem_data(d_mem_data),
        .core_rst_n(a_crn), .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_to),
        .hang(a_hang), .halt_value(a_hv), .cycle_count(a_cc), .write_count(a_wc)
    );

    polirv_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(16), .STALL_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .i_mem_addr(i_mem_addr),
        .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr), .d_mem_data(d_mem_data),
        .core_rst_n(b_crn), .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_to),
        .hang(b_hang), .halt_value(b_hv), .cycle_count(b_cc), .write_count(b_wc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // kind: 0 pass, 1 fail, 2 timeout, 3 hang
    typedef struct {
        int          kind;
        int          k;
        int          wc;
        logic [63:0] hv;
        int          edge_n;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [5:0]  hold_addr;
    logic [5:0]  s_addr[L];
    logic        s_we[L];
    logic [5:0]  s_daddr[L];
    logic [63:0] s_data[L];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walk the program cycle by cycle and report which rule ends the run first.
    function automatic exp_t model(input int max_c, input int stall_c);
        exp_t       e;
        int         s = 0;
        int         wc = 0;
        logic [5:0] prev = hold_addr;
        e.kind = -1; e.hv = '0; e.k = L; e.wc = 0; e.edge_n = 0;
        for (int k = 0; k < L; k++) begin
            if (s_we[k]) wc++;
            s = (s_addr[k] == prev) ? s + 1 : 0;
            prev = s_addr[k];
            if (s_we[k] && s_daddr[k] == 6'd63) begin
                e.kind = (s_data[k] == 64'd1) ? 0 : 1;
                e.hv   = s_data[k];
            end else if (k == max_c - 1) begin
                e.kind = 2;
            end else if (stall_c != 0 && s == stall_c) begin
                e.kind = 3;
            end
            if (e.kind >= 0) begin
                e.k  = k;
                e.wc = wc;
                return e;
            end
        end
        return e;
    endfunction

    task automatic mon_check(input string tag, input exp_t e, input logic [2:0] flags,
                             input logic [15:0] cc, input logic [15:0] wc,
                             input logic [63:0] hv, input logic [1:0] crn_busy);
        logic [2:0] ef;
        ef = (e.kind == 0) ? 3'b100 : (e.kind == 2) ? 3'b010 : (e.kind == 3) ? 3'b001 : 3'b000;
        check({tag, "_flags"}, 64'(flags), 64'(ef));
        check({tag, "_cycle_count"}, 64'(cc), 64'(e.k + 1));
        check({tag, "_write_count"}, 64'(wc), 64'(e.wc));
        check({tag, "_halt_value"}, hv, e.hv);
        check({tag, "_crn_busy"}, 64'(crn_busy), 64'd0);
        check({tag, "_done_edge"}, 64'(cyc), 64'(e.edge_n));
    endtask

    initial begin : mon_a
        logic pd = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_done && !pd) begin
                if (q_a.size() == 0) check("a_unexpected_done", 64'd1, 64'd0);
                else begin
                    e = q_a.pop_front();
                    mon_check("a", e, {a_pass, a_to, a_hang}, a_cc, a_wc, a_hv, {a_crn, a_busy});
                end
            end
            pd = a_done;
        end
    end

    initial begin : mon_b
        logic pd = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_done && !pd) begin
                if (q_b.size() == 0) check("b_unexpected_done", 64'd1, 64'd0);
                else begin
                    e = q_b.pop_front();
                    mon_check("b", e, {b_pass, b_to, b_hang}, b_cc, b_wc, b_hv, {b_crn, b_busy});
                end
            end
            pd = b_done;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_a_flags"}, 64'({a_crn, a_busy, a_done, a_pass, a_to, a_hang}), 64'd0);
        check({tag, "_a_counts"}, 64'({a_cc, a_wc}), 64'd0);
        check({tag, "_a_halt_value"}, a_hv, 64'd0);
        check({tag, "_b_flags"}, 64'({b_crn, b_busy, b_done, b_pass, b_to, b_hang}), 64'd0);
        check({tag, "_b_counts"}, 64'({b_cc, b_wc}), 64'd0);
    endtask

    task automatic fill_inc();
        hold_addr = 6'd0;
        for (int k = 0; k < L; k++) begin
            s_addr[k] = 6'(k + 1);
            s_we[k] = 1'b0; s_daddr[k] = 6'd0; s_data[k] = 64'd0;
        end
    endtask

    task automatic fill_random();
        int         mode;
        int         k0;
        logic [5:0] prev;
        hold_addr = 6'($urandom);
        prev = hold_addr;
        for (int k = 0; k < L; k++) begin
            s_addr[k]  = ($urandom_range(0, 9) < 3) ? prev : 6'($urandom);
            prev       = s_addr[k];
            s_we[k]    = ($urandom_range(0, 9) < 4);
            s_daddr[k] = 6'($urandom_range(0, 62));
            s_data[k]  = {$urandom, $urandom};
        end
        mode = $urandom_range(0, 3);
        if (mode >= 2) begin
            k0 = $urandom_range(0, 30);
            for (int k = k0 + 1; k < L; k++) s_addr[k] = s_addr[k0];
        end
        if (mode == 0 || mode == 3) begin
            k0 = $urandom_range(0, L - 1);
            s_we[k0]    = 1'b1;
            s_daddr[k0] = 6'd63;
            s_data[k0]  = ($urandom_range(0, 1) == 1) ? 64'd1 : {$urandom, $urandom};
        end
    endtask

    task automatic run_one();
        exp_t ea, eb;
        int   pulse_k;
        ea = model(40, 8);
        eb = model(16, 0);
        pulse_k = (ea.k > 3 && eb.k > 3) ? 3 : -1;
        @(posedge clk); #1;
        start = 1'b1; i_mem_addr = hold_addr;
        // Halt-looking write outside RUN must be ignored.
        d_mem_we = 1'b1; d_mem_addr = 6'd63; d_mem_data = 64'd1;
        @(posedge clk); #1;
        start = 1'b0;
        ea.edge_n = cyc + 3 + ea.k;
        eb.edge_n = cyc + 3 + eb.k;
        q_a.push_back(ea);
        q_b.push_back(eb);
        check("hold0_a_flags", 64'({a_crn, a_busy, a_done, a_pass, a_to, a_hang}), 64'b010000);
        check("hold0_a_counts", 64'({a_cc, a_wc}), 64'd0);
        check("hold0_a_halt_value", a_hv, 64'd0);
        check("hold0_b_flags", 64'({b_crn, b_busy, b_done, b_pass, b_to, b_hang}), 64'b010000);
        @(posedge clk); #1;
        check("hold1_a_crn_busy", 64'({a_crn, a_busy}), 64'b01);
        @(posedge clk); #1;
        check("run0_a_crn_busy", 64'({a_crn, a_busy}), 64'b11);
        for (int k = 0; k < L; k++) begin
            start      = (k == pulse_k);
            i_mem_addr = s_addr[k];
            d_mem_we   = s_we[k];
            d_mem_addr = s_daddr[k];
            d_mem_data = s_data[k];
            @(posedge clk); #1;
        end
        start = 1'b0; d_mem_we = 1'b0;
        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
        check("scoreboard_drained", 64'(q_a.size() + q_b.size()), 64'd0);
        q_a.delete();
        q_b.delete();
    endtask

    task automatic directed_halt(input int at, input logic [63:0] val);
        fill_inc();
        s_we[2] = 1'b1; s_daddr[2] = 6'd10; s_data[2] = 64'h55;
        s_we[5] = 1'b1; s_daddr[5] = 6'd11; s_data[5] = 64'h66;
        s_we[7] = 1'b1; s_daddr[7] = 6'd12; s_data[7] = 64'h77;
        s_we[at] = 1'b1; s_daddr[at] = 6'd63; s_data[at] = val;
        run_one();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin : main
        rst_n = 1'b1; start = 1'b0; i_mem_addr = '0;
        d_mem_we = 1'b0; d_mem_addr = '0; d_mem_data = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_zero("idle_after_reset");

        directed_halt(10, 64'd1);
        directed_halt(10, 64'hDEAD);
        fill_inc();
        run_one();
        directed_halt(15, 64'd1);
        fill_inc();
        hold_addr = 6'd5;
        for (int k = 0; k < L; k++) s_addr[k] = 6'd5;
        run_one();

        for (int n = 0; n < 25; n++) begin
            fill_random();
            run_one();
        end

        // Asynchronous reset in the middle of a run.
        fill_inc();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            #1 i_mem_addr = s_addr[k];
            @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1 check_zero("midrun_reset");
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_zero("stay_idle");

        directed_halt(10, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
